// File: rtl/display_defs_pkg.sv
// Shared definitions for the I/O seven-segment display driver:
// segment codes, digit table, channel FSM encodings and the digit-pair payload.
package display_defs;

  localparam int unsigned SEG_W  = 7;
  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CH_W   = 2;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_DASH  = 7'h3F;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_STORE = 2'd2;

  typedef struct packed {
    logic [SEG_W-1:0] tens;
    logic [SEG_W-1:0] ones;
  } seg_pair_t;

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show blank.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] digit);
    case (digit)
      4'd0:    seg_decode = 7'h40;
      4'd1:    seg_decode = 7'h79;
      4'd2:    seg_decode = 7'h24;
      4'd3:    seg_decode = 7'h30;
      4'd4:    seg_decode = 7'h19;
      4'd5:    seg_decode = 7'h12;
      4'd6:    seg_decode = 7'h02;
      4'd7:    seg_decode = 7'h78;
      4'd8:    seg_decode = 7'h00;
      4'd9:    seg_decode = 7'h10;
      default: seg_decode = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_dabble_unit.sv
// Sequential double-dabble converter: one add-3/shift step per cycle,
// BIN_W steps after start, digits valid while done is high.
module bcd_dabble_unit #(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  last_c,
  output logic                  done
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  logic [SR_W-1:0]  sr_q;
  logic [SR_W-1:0]  sr_adj_c;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Add-3 correction on every BCD nibble that would overflow on the next shift.
  always_comb begin
    sr_adj_c = sr_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (sr_q[BIN_W + 4*i +: 4] >= 4'd5)
        sr_adj_c[BIN_W + 4*i +: 4] = sr_q[BIN_W + 4*i +: 4] + 4'd3;
    end
  end

  assign last_c = busy_q && (cnt_q == CNT_W'(BIN_W - 1));
  assign digits = sr_q[SR_W-1 -: BCD_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        sr_q   <= {BCD_W'(0), bin};
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        sr_q  <= {sr_adj_c[SR_W-2:0], 1'b0};
        cnt_q <= cnt_q + CNT_W'(1);
        if (last_c) begin
          busy_q <= 1'b0;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/io_display_driver.sv
// Round-robin display driver: converts each of three output ports to two
// decimal digits with a shared double-dabble unit and drives six HEX displays.
module io_display_driver
  import display_defs::*;
#(
  parameter int unsigned BIN_W  = 7,
  parameter int unsigned DIGITS = 2,
  parameter int unsigned LIMIT  = 99
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       out_port0,
  input  logic [31:0]       out_port1,
  input  logic [31:0]       out_port2,
  output logic [SEG_W-1:0]  hex0,
  output logic [SEG_W-1:0]  hex1,
  output logic [SEG_W-1:0]  hex2,
  output logic [SEG_W-1:0]  hex3,
  output logic [SEG_W-1:0]  hex4,
  output logic [SEG_W-1:0]  hex5,
  output logic              frame_done
);

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [CH_W-1:0]     ch_q;
  logic [CH_W-1:0]     ch_d;
  logic                ovf_q;
  logic                start_c;
  logic                store_c;
  logic [31:0]         port_sel_c;
  logic [4*DIGITS-1:0] dab_digits;
  logic                dab_last_c;
  logic                dab_done;
  seg_pair_t           pair_c;

  always_comb begin
    case (ch_q)
      CH_W'(0): port_sel_c = out_port0;
      CH_W'(1): port_sel_c = out_port1;
      default:  port_sel_c = out_port2;
    endcase
  end

  bcd_dabble_unit #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_dabble (
    .clock  (clock),
    .reset  (reset),
    .start  (start_c),
    .bin    (port_sel_c[BIN_W-1:0]),
    .digits (dab_digits),
    .last_c (dab_last_c),
    .done   (dab_done)
  );

  // Channel FSM next-state logic.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    start_c = 1'b0;
    store_c = 1'b0;
    case (state_q)
      ST_LOAD: begin
        start_c = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (dab_last_c) state_d = ST_STORE;
      end
      ST_STORE: begin
        store_c = 1'b1;
        ch_d    = (ch_q == CH_W'(NUM_CH - 1)) ? '0 : ch_q + CH_W'(1);
        state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Overflow is judged on the full unsigned port value, not the converted bits.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LOAD;
      ch_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      if (start_c) ovf_q <= (port_sel_c > 32'(LIMIT));
    end
  end

  always_comb begin
    pair_c.tens = seg_decode(dab_digits[7:4]);
    pair_c.ones = seg_decode(dab_digits[3:0]);
    if (ovf_q) begin
      pair_c.tens = SEG_DASH;
      pair_c.ones = SEG_DASH;
    end
  end

  // Output registers: each pair holds until its channel's next store.
  always_ff @(posedge clock) begin
    if (reset) begin
      hex0       <= SEG_BLANK;
      hex1       <= SEG_BLANK;
      hex2       <= SEG_BLANK;
      hex3       <= SEG_BLANK;
      hex4       <= SEG_BLANK;
      hex5       <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      frame_done <= store_c && (ch_q == CH_W'(NUM_CH - 1));
      if (store_c && dab_done) begin
        case (ch_q)
          CH_W'(0): begin
            hex5 <= pair_c.tens;
            hex4 <= pair_c.ones;
          end
          CH_W'(1): begin
            hex3 <= pair_c.tens;
            hex2 <= pair_c.ones;
          end
          default: begin
            hex1 <= pair_c.tens;
            hex0 <= pair_c.ones;
          end
        endcase
      end
    end
  end

endmodule
